// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates ids at issue, captures results out of order,
// retires in program order and flushes everything when a mispredicted branch retires.
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 issueValid,
  input  logic [4:0]           issueDest,
  input  logic                 issueIsBranch,
  output logic                 robFull,
  output logic [ROB_WIDTH-1:0] issueRobId,
  input  logic                 wbValid,
  input  logic [ROB_WIDTH-1:0] wbRobId,
  input  logic [31:0]          wbValue,
  input  logic                 wbMispredict,
  input  logic [31:0]          wbTarget,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  input  logic [ROB_WIDTH-1:0] robRs1Dep,
  output logic                 robRs1Ready,
  output logic [31:0]          robRs1Value,
  input  logic [ROB_WIDTH-1:0] robRs2Dep,
  output logic                 robRs2Ready,
  output logic [31:0]          robRs2Value,
  output logic                 flushOut,
  output logic [31:0]          flushPc
);

  localparam int DEPTH = 1 << ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] DEPTH_CNT = (ROB_WIDTH + 1)'(DEPTH);

  // Handshakes: an issue is taken on a posedge where issueValid is high and robFull is low
  // (no stall, the instruction unit must hold it); wbValid and regUpdateValid are one-cycle
  // strobes with no backpressure.

  logic [DEPTH-1:0]     busy_q;
  logic [DEPTH-1:0]     ready_q;
  logic [DEPTH-1:0]     branch_q;
  logic [DEPTH-1:0]     mispred_q;
  logic [4:0]           dest_q   [DEPTH];
  logic [31:0]          value_q  [DEPTH];
  logic [31:0]          target_q [DEPTH];
  logic [ROB_WIDTH-1:0] head_q;
  logic [ROB_WIDTH-1:0] tail_q;
  logic [ROB_WIDTH:0]   count_q;

  logic do_alloc;
  logic do_wb;
  logic do_commit;
  logic do_flush;

  assign robFull    = (count_q == DEPTH_CNT);
  assign issueRobId = tail_q;

  // Fullness is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign do_alloc  = issueValid && !robFull;
  assign do_wb     = wbValid && busy_q[wbRobId];
  assign do_commit = (count_q != '0) && ready_q[head_q];
  assign do_flush  = do_commit && mispred_q[head_q];

  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      busy_q         <= '0;
      ready_q        <= '0;
      mispred_q      <= '0;
      regUpdateValid <= 1'b0;
      regUpdateDest  <= '0;
      regUpdateValue <= '0;
      regUpdateRobId <= '0;
      flushOut       <= 1'b0;
      flushPc        <= '0;
    end else begin
      regUpdateValid <= do_commit;
      if (do_commit) begin
        regUpdateDest  <= dest_q[head_q];
        regUpdateValue <= value_q[head_q];
        regUpdateRobId <= head_q;
      end
      flushOut <= do_flush;
      if (do_flush) begin
        flushPc <= target_q[head_q];
      end

      if (do_flush) begin
        head_q    <= '0;
        tail_q    <= '0;
        count_q   <= '0;
        busy_q    <= '0;
        ready_q   <= '0;
        mispred_q <= '0;
      end else begin
        if (do_alloc) begin
          busy_q[tail_q]   <= 1'b1;
          ready_q[tail_q]  <= 1'b0;
          branch_q[tail_q] <= issueIsBranch;
          tail_q           <= tail_q + 1'b1;
        end
        if (do_wb) begin
          ready_q[wbRobId]   <= 1'b1;
          mispred_q[wbRobId] <= wbMispredict && branch_q[wbRobId];
        end
        // Placed after the writeback so a retiring head never stays marked ready.
        if (do_commit) begin
          busy_q[head_q]  <= 1'b0;
          ready_q[head_q] <= 1'b0;
          head_q          <= head_q + 1'b1;
        end
        count_q <= count_q + {{ROB_WIDTH{1'b0}}, do_alloc} - {{ROB_WIDTH{1'b0}}, do_commit};
      end
    end
  end

  // Payload storage needs no reset: it is only read behind busy/ready.
  always_ff @(posedge clockIn) begin
    if (resetIn && !do_flush) begin
      if (do_alloc) begin
        dest_q[tail_q] <= issueDest;
      end
      if (do_wb) begin
        value_q[wbRobId]  <= wbValue;
        target_q[wbRobId] <= wbTarget;
      end
    end
  end

  always_comb begin
    robRs1Ready = 1'b0;
    robRs1Value = '0;
    if (ready_q[robRs1Dep]) begin
      robRs1Ready = 1'b1;
      robRs1Value = value_q[robRs1Dep];
    end else if (wbValid && (wbRobId == robRs1Dep)) begin
      robRs1Ready = 1'b1;
      robRs1Value = wbValue;
    end
  end

  always_comb begin
    robRs2Ready = 1'b0;
    robRs2Value = '0;
    if (ready_q[robRs2Dep]) begin
      robRs2Ready = 1'b1;
      robRs2Value = value_q[robRs2Dep];
    end else if (wbValid && (wbRobId == robRs2Dep)) begin
      robRs2Ready = 1'b1;
      robRs2Value = wbValue;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by random traffic,
// all compared against a queue-based program-order model of the buffer.
module tb_reorder_buffer;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        issueValid;
  logic [4:0]  issueDest;
  logic        issueIsBranch;
  logic        robFull;
  logic [3:0]  issueRobId;
  logic        wbValid;
  logic [3:0]  wbRobId;
  logic [31:0] wbValue;
  logic        wbMispredict;
  logic [31:0] wbTarget;
  logic        regUpdateValid;
  logic [4:0]  regUpdateDest;
  logic [31:0] regUpdateValue;
  logic [3:0]  regUpdateRobId;
  logic [3:0]  robRs1Dep;
  logic        robRs1Ready;
  logic [31:0] robRs1Value;
  logic [3:0]  robRs2Dep;
  logic        robRs2Ready;
  logic [31:0] robRs2Value;
  logic        flushOut;
  logic [31:0] flushPc;

  always #5 clockIn = ~clockIn;

  reorder_buffer #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .issueValid(issueValid), .issueDest(issueDest), .issueIsBranch(issueIsBranch),
    .robFull(robFull), .issueRobId(issueRobId),
    .wbValid(wbValid), .wbRobId(wbRobId), .wbValue(wbValue),
    .wbMispredict(wbMispredict), .wbTarget(wbTarget),
    .regUpdateValid(regUpdateValid), .regUpdateDest(regUpdateDest),
    .regUpdateValue(regUpdateValue), .regUpdateRobId(regUpdateRobId),
    .robRs1Dep(robRs1Dep), .robRs1Ready(robRs1Ready), .robRs1Value(robRs1Value),
    .robRs2Dep(robRs2Dep), .robRs2Ready(robRs2Ready), .robRs2Value(robRs2Value),
    .flushOut(flushOut), .flushPc(flushPc)
  );

  // Program-order model: one queue element per in-flight instruction, oldest first.
  typedef struct {
    logic [3:0]  id;
    logic [4:0]  dest;
    bit          br;
    bit          done;
    logic [31:0] value;
    bit          mis;
    logic [31:0] tgt;
  } ent_t;

  ent_t        rob_m[$];
  logic [3:0]  m_tail;
  logic [40:0] exp_q[$];
  bit          m_rv;
  bit          m_fl;
  logic [31:0] m_fpc;
  bit          synced = 1'b0;
  int          total = 0;
  int          pass_cnt = 0;
  int          fail_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [32:0] m_lookup(input logic [3:0] dep);
    foreach (rob_m[i])
      if (rob_m[i].id == dep && rob_m[i].done) return {1'b1, rob_m[i].value};
    if (wbValid && wbRobId == dep) return {1'b1, wbValue};
    return 33'd0;
  endfunction

  task automatic idle();
    issueValid = 0; issueDest = 0; issueIsBranch = 0;
    wbValid = 0; wbRobId = 0; wbValue = 0; wbMispredict = 0; wbTarget = 0;
  endtask

  // One clock: check combinational outputs, advance the model, then check registered outputs.
  task automatic tick();
    logic [32:0] l1;
    logic [32:0] l2;
    logic [40:0] e;
    bit c;
    bit al;
    bit rst;
    ent_t h;
    #1;
    rst = !resetIn;
    if (synced) begin
      check("robFull", robFull, rob_m.size() == 16);
      check("issueRobId", issueRobId, m_tail);
      l1 = m_lookup(robRs1Dep);
      l2 = m_lookup(robRs2Dep);
      check("rs1Ready", robRs1Ready, l1[32]);
      check("rs1Value", robRs1Value, l1[31:0]);
      check("rs2Ready", robRs2Ready, l2[32]);
      check("rs2Value", robRs2Value, l2[31:0]);
    end
    if (rst) begin
      rob_m.delete(); exp_q.delete();
      m_tail = 0; m_rv = 0; m_fl = 0; m_fpc = 0; synced = 1;
    end else begin
      al = issueValid && rob_m.size() < 16;
      c  = rob_m.size() != 0 && rob_m[0].done;
      m_rv = c;
      m_fl = 0;
      if (c) begin
        h = rob_m.pop_front();
        exp_q.push_back({h.id, h.dest, h.value});
        m_fl = h.mis;
        if (h.mis) m_fpc = h.tgt;
      end
      if (wbValid)
        foreach (rob_m[i])
          if (rob_m[i].id == wbRobId) begin
            rob_m[i].done  = 1;
            rob_m[i].value = wbValue;
            rob_m[i].mis   = wbMispredict && rob_m[i].br;
            rob_m[i].tgt   = wbTarget;
          end
      if (m_fl) begin
        rob_m.delete();
        m_tail = 0;
      end else if (al) begin
        rob_m.push_back('{id: m_tail, dest: issueDest, br: issueIsBranch, done: 1'b0,
                          value: 32'd0, mis: 1'b0, tgt: 32'd0});
        m_tail++;
      end
    end
    @(posedge clockIn);
    @(negedge clockIn);
    check("regUpdateValid", regUpdateValid, m_rv);
    check("flushOut", flushOut, m_fl);
    check("flushPc", flushPc, m_fpc);
    if (rst) begin
      check("rst_regUpdateDest", regUpdateDest, 0);
      check("rst_regUpdateValue", regUpdateValue, 0);
      check("rst_regUpdateRobId", regUpdateRobId, 0);
    end
    if (regUpdateValid === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("commit_entry", {regUpdateRobId, regUpdateDest, regUpdateValue}, e);
    end
  endtask

  task automatic do_reset();
    resetIn = 0;
    tick();
    tick();
    resetIn = 1;
  endtask

  initial begin
    idle();
    robRs1Dep = 0;
    robRs2Dep = 0;
    do_reset();
    check("reset_robFull", robFull, 0);
    check("reset_issueRobId", issueRobId, 0);

    // In-order retirement of out-of-order results.
    issueValid = 1;
    issueDest = 1; tick();
    issueDest = 2; tick();
    issueDest = 3; tick();
    idle();
    wbValid = 1;
    wbRobId = 1; wbValue = 32'h22; tick();
    wbRobId = 0; wbValue = 32'h11; tick();
    wbRobId = 2; wbValue = 32'h33; tick();
    check("s1_c0_dest", regUpdateDest, 1);
    check("s1_c0_value", regUpdateValue, 32'h11);
    idle(); tick();
    check("s1_c1_dest", regUpdateDest, 2);
    check("s1_c1_value", regUpdateValue, 32'h22);
    tick();
    check("s1_c2_id", regUpdateRobId, 2);
    check("s1_c2_value", regUpdateValue, 32'h33);

    // Fill to full, ignored issue, pop while full, wrap-around allocation.
    do_reset();
    issueValid = 1;
    for (int i = 0; i < 16; i++) begin
      issueDest = 5'(i + 1);
      tick();
    end
    check("s2_full", robFull, 1);
    tick();
    check("s2_tail_held", issueRobId, 0);
    wbValid = 1; wbRobId = 0; wbValue = 32'hABCD; tick();
    wbValid = 0; tick();
    check("s2_full_pop_dest", regUpdateDest, 1);
    check("s2_not_full", robFull, 0);
    check("s2_no_alloc", issueRobId, 0);
    tick();
    check("s2_wrap", issueRobId, 1);
    idle();

    // Mispredicted branch at id 2 flushes younger entries.
    do_reset();
    issueValid = 1;
    for (int i = 0; i < 6; i++) begin
      issueDest = 5'(i + 4);
      issueIsBranch = (i == 2);
      tick();
    end
    idle();
    wbValid = 1; wbRobId = 2; wbValue = 32'h2; wbMispredict = 1; wbTarget = 32'h1000; tick();
    wbMispredict = 0; wbTarget = 0;
    wbRobId = 0; wbValue = 32'h100; tick();
    wbRobId = 1; wbValue = 32'h101; tick();
    wbValid = 0; tick();
    issueValid = 1; issueDest = 9; wbValid = 1; wbRobId = 4; wbValue = 32'h55; tick();
    check("s4_flush", flushOut, 1);
    check("s4_flushPc", flushPc, 32'h1000);
    check("s4_branch_commit", regUpdateRobId, 2);
    check("s4_tail_zero", issueRobId, 0);
    issueValid = 0; tick();
    check("s4_flush_one_cycle", flushOut, 0);
    check("s4_stale_wb", regUpdateValid, 0);
    idle();

    // Bypass lookup, then readiness from storage.
    issueValid = 1;
    for (int i = 0; i < 6; i++) begin
      issueDest = 5'(i + 10);
      tick();
    end
    idle();
    wbValid = 1; wbRobId = 5; wbValue = 32'hDEAD;
    robRs1Dep = 5; robRs2Dep = 4;
    #1;
    check("s5_bypass_ready", robRs1Ready, 1);
    check("s5_bypass_value", robRs1Value, 32'hDEAD);
    check("s5_other_not_ready", robRs2Ready, 0);
    tick();
    wbValid = 0;
    #1;
    check("s5_stored_ready", robRs1Ready, 1);
    check("s5_stored_value", robRs1Value, 32'hDEAD);

    // Reset while entries are in flight.
    resetIn = 0; tick(); resetIn = 1;
    check("s6_count_zero", robFull, 0);
    check("s6_tail_zero", issueRobId, 0);
    check("s6_no_commit", regUpdateValid, 0);
    check("s6_no_flush", flushOut, 0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      resetIn       = ($urandom_range(0, 249) != 0);
      issueValid    = ($urandom_range(0, 2) != 0);
      issueDest     = 5'($urandom);
      issueIsBranch = ($urandom_range(0, 3) == 0);
      wbValid       = ($urandom_range(0, 1) == 1);
      if (rob_m.size() > 0 && $urandom_range(0, 7) != 0)
        wbRobId = rob_m[$urandom_range(0, rob_m.size() - 1)].id;
      else
        wbRobId = 4'($urandom);
      wbValue      = $urandom;
      wbMispredict = ($urandom_range(0, 7) == 0);
      wbTarget     = $urandom;
      robRs1Dep    = 4'($urandom);
      robRs2Dep    = (rob_m.size() > 0) ? rob_m[$urandom_range(0, rob_m.size() - 1)].id
                                        : 4'($urandom);
      tick();
    end
    resetIn = 1;
    idle();
    for (int n = 0; n < 20; n++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between the instruction unit (allocation), the execution units / common data bus (writeback) and the register file (commit).
- Allocates a ROB id per issued instruction and captures results out of order.
- Retires strictly in program order, driving the register-file update port one entry per cycle.
- Answers operand-readiness lookups and performs a full flush when a mispredicted branch commits.

Parameters:
- ROB_WIDTH, 4, index width; depth = 2^ROB_WIDTH entries (16 by default).

Ports:
- clockIn  input  1  single clock
- resetIn  input  1  one clock; reset is synchronous and active-low
- issueValid  input  1  instruction unit requests an entry this cycle
- issueDest  input  5  destination register (0 = none)
- issueIsBranch  input  1  entry is a branch (may mispredict)
- robFull  output  1  no entry free; issue ignored while high
- issueRobId  output  ROB_WIDTH  id granted to the current issue (= tail)
- wbValid  input  1  result broadcast valid
- wbRobId  input  ROB_WIDTH  entry being completed
- wbValue  input  32  result value
- wbMispredict  input  1  branch result was mispredicted
- wbTarget  input  32  correct PC for a mispredicted branch
- regUpdateValid  output  1  commit strobe to register file
- regUpdateDest  output  5  committed destination
- regUpdateValue  output  32  committed value
- regUpdateRobId  output  ROB_WIDTH  committed entry id
- robRs1Dep  input  ROB_WIDTH  rs1 dependency lookup id
- robRs1Ready  output  1  rs1 dependency has a value
- robRs1Value  output  32  rs1 value
- robRs2Dep  input  ROB_WIDTH  rs2 dependency lookup id
- robRs2Ready  output  1  rs2 dependency has a value
- robRs2Value  output  32  rs2 value
- flushOut  output  1  one-cycle pipeline flush pulse
- flushPc  output  32  redirect PC, valid with flushOut

Behaviour:
- State per entry: busy, ready, isBranch, mispredict, dest[4:0], value[31:0], target[31:0].
- Pointers: head, tail (ROB_WIDTH bits, wrap modulo depth); count (ROB_WIDTH+1 bits).
- Reset (resetIn low at posedge): head = tail = count = 0; all busy/ready cleared.
- Reset values of outputs: regUpdateValid = 0, flushOut = 0, regUpdate* = 0, flushPc = 0.
- Reset applied mid-operation discards every entry and forces the same state.
- robFull = (count == 2^ROB_WIDTH), combinational from registered count. issueRobId = tail, combinational.
- Allocate: issueValid && !robFull at posedge writes entry[tail] with busy = 1, ready = 0, dest, isBranch; then tail++.
  - Full is evaluated before any same-cycle commit, so no allocation occurs while full, even if a commit frees a slot that cycle.
- Writeback: wbValid && busy[wbRobId] at posedge sets ready = 1, value = wbValue, mispredict = wbMispredict && isBranch, target = wbTarget.
  - Writeback to a non-busy entry is ignored.
- Commit: at posedge, if count != 0 && ready[head], pop head (busy = 0, head++).
  - Next cycle, regUpdateValid = 1 with dest/value/id of the popped entry; otherwise regUpdateValid = 0.
  - Result: commit latency is 1 cycle after ready; at most one commit per cycle.
  - Commit to dest 0 still pulses regUpdateValid with dest 0; the register file discards it.
- Simultaneous allocate + commit: count unchanged; tail and head both advance.
- Writeback and commit of the same entry in one cycle: not possible, because ready is registered. The commit happens the following cycle.
- Flush: when the popped head entry has mispredict = 1:
  - next cycle flushOut = 1, flushPc = target, regUpdateValid = 1 for that branch (its dest/value still commit);
  - in the same posedge all entries are cleared and head = tail = count = 0;
  - issue and writeback arriving in that posedge are discarded;
  - flushOut lasts exactly one cycle.
- Lookup (combinational), robRsNReady:
  - = 1 if ready[robRsNDep];
  - else = 1 if wbValid && wbRobId == robRsNDep, with robRsNValue = wbValue (bypass);
  - robRsNValue = value[robRsNDep] when ready, else wbValue when bypassed, else 0.

Test Plan:
- Reset, then issue 3 entries (dest 1,2,3) → issueRobId 0,1,2; writeback id 1 = 0x22, then id 0 = 0x11, then id 2 = 0x33 → commits in order: (1, 0x11, id 0), (2, 0x22, id 1), (3, 0x33, id 2) on consecutive cycles.
- Issue 16 entries with no writeback → robFull = 1; a 17th issue is ignored and tail stays 0. Writeback id 0 → commit; robFull drops the cycle after the pop. The next issue gets id 0 (wrap).
- Full ROB, head ready, issueValid high same cycle → head pops, no allocation that cycle, count = 15.
- Branch at id 2 written back with wbMispredict = 1, target 0x1000; entries 3..5 busy → after ids 0,1 commit, id 2 commits with flushOut = 1, flushPc = 0x1000. Next cycle count = 0, issueRobId = 0, and a stale writeback to id 4 is ignored.
- Lookup id 5 not ready while wbValid && wbRobId = 5, wbValue = 0xDEAD → robRs1Ready = 1 and robRs1Value = 0xDEAD in the same cycle. Next cycle it stays ready from storage.
- Drive resetIn low while 6 entries are in flight → next cycle count = 0, regUpdateValid = 0, flushOut = 0, robFull = 0.
